// File: rtl/decode_ctrl_stage.sv
// RV32I decode stage: opcode -> control bundle, one registered slot, load-use bubble, stall counter.
// Optional F-extension decode and fp load-use check enabled by `define DECODE_CTRL_STAGE_FPU_EN.
module decode_ctrl_stage #(
   parameter int unsigned PC_W           = 32,
   parameter bit          LOAD_USE_STALL = 1'b1,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_insn,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [31:0]      out_insn,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic             out_reg_write,
   output logic             out_imm_data,
   output logic             out_mem_to_reg,
   output logic             out_branch,
   output logic             out_wb_pc,
   output logic             out_cond_b,
   output logic             out_store,
   output logic             out_jalr,
   output logic             out_auipc,
   output logic             out_lui,
   output logic             out_is_fstore,
   output logic             out_fp_reg_write,
   output logic             out_illegal,
   output logic [1:0]       out_alu_op,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_FLOAD  = 7'b0000111,
      OPC_OPIMM  = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_FSTORE = 7'b0100111,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_OPFP   = 7'b1010011,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   typedef struct packed {
      logic       reg_write;
      logic       imm_data;
      logic       mem_to_reg;
      logic       branch;
      logic       wb_pc;
      logic       cond_b;
      logic       store;
      logic       jalr;
      logic       auipc;
      logic       lui;
      logic       is_fstore;
      logic       fp_reg_write;
      logic       illegal;
      logic [1:0] alu_op;
   } ctrl_t;

   logic [6:0] opc;
   logic       is_load, is_opimm, is_auipc, is_store, is_op, is_lui;
   logic       is_branch, is_jalr, is_jal, is_fload, is_fstore, is_opfp;
   logic       uses_rs1, uses_rs2;
   logic [4:0] in_rs1, in_rs2;
   logic       int_hz, fp_hz, hazard, accept;
   ctrl_t      ctrl_d, ctrl_q;
   logic              valid_q;
   logic [PC_W-1:0]   pc_q;
   logic [31:0]       insn_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   assign opc    = in_insn[6:0];
   assign in_rs1 = in_insn[19:15];
   assign in_rs2 = in_insn[24:20];

   assign is_load   = (opc == OPC_LOAD);
   assign is_opimm  = (opc == OPC_OPIMM);
   assign is_auipc  = (opc == OPC_AUIPC);
   assign is_store  = (opc == OPC_STORE);
   assign is_op     = (opc == OPC_OP);
   assign is_lui    = (opc == OPC_LUI);
   assign is_branch = (opc == OPC_BRANCH);
   assign is_jalr   = (opc == OPC_JALR);
   assign is_jal    = (opc == OPC_JAL);
`ifdef DECODE_CTRL_STAGE_FPU_EN
   assign is_fload  = (opc == OPC_FLOAD);
   assign is_fstore = (opc == OPC_FSTORE);
   assign is_opfp   = (opc == OPC_OPFP);
`else
   assign is_fload  = 1'b0;
   assign is_fstore = 1'b0;
   assign is_opfp   = 1'b0;
`endif

   always_comb begin
      ctrl_d              = '0;
      ctrl_d.reg_write    = is_opimm | is_op | is_jal | is_jalr | is_load | is_lui | is_auipc;
      ctrl_d.imm_data     = is_opimm | is_load | is_store | is_jalr | is_lui | is_auipc
                          | is_fload | is_fstore;
      ctrl_d.mem_to_reg   = is_load;
      ctrl_d.branch       = is_jal | is_jalr | is_branch;
      ctrl_d.wb_pc        = is_jal | is_jalr;
      ctrl_d.cond_b       = is_branch;
      ctrl_d.store        = is_store | is_fstore;
      ctrl_d.jalr         = is_jalr;
      ctrl_d.auipc        = is_auipc;
      ctrl_d.lui          = is_lui;
      ctrl_d.is_fstore    = is_fstore;
      ctrl_d.fp_reg_write = is_fload | is_opfp;
      ctrl_d.illegal      = !(is_load | is_opimm | is_auipc | is_store | is_op | is_lui
                            | is_branch | is_jalr | is_jal | is_fload | is_fstore | is_opfp);
      if (is_opimm)       ctrl_d.alu_op = 2'b01;
      else if (is_op)     ctrl_d.alu_op = 2'b11;
      else if (is_branch) ctrl_d.alu_op = 2'b00;
      else                ctrl_d.alu_op = 2'b10;
   end

   assign uses_rs1 = is_op | is_opimm | is_load | is_store | is_branch | is_jalr | is_fload | is_fstore;
   assign uses_rs2 = is_op | is_store | is_branch;

   // Held integer load with a real destination blocks any consumer of that register.
   assign int_hz = valid_q & ctrl_q.mem_to_reg & (out_rd != 5'd0)
                 & ((uses_rs1 & (in_rs1 == out_rd)) | (uses_rs2 & (in_rs2 == out_rd)));

`ifdef DECODE_CTRL_STAGE_FPU_EN
   assign fp_hz = valid_q & ctrl_q.fp_reg_write & (insn_q[6:0] == OPC_FLOAD)
                & ((is_opfp & ((in_rs1 == out_rd) | (in_rs2 == out_rd)))
                 | (is_fstore & (in_rs2 == out_rd)));
`else
   assign fp_hz = 1'b0;
`endif

   assign hazard   = LOAD_USE_STALL ? (int_hz | fp_hz) : 1'b0;
   assign in_ready = !flush & (!valid_q | out_ready) & !hazard;
   assign accept   = in_valid & in_ready;

   always_comb begin
      cnt_d = cnt_q;
      if (in_valid & hazard & !flush & ~&cnt_q)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         pc_q    <= '0;
         insn_q  <= '0;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (flush) begin
            valid_q <= 1'b0;
         end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            pc_q    <= in_pc;
            insn_q  <= in_insn;
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign out_valid        = valid_q;
   assign out_pc           = pc_q;
   assign out_insn         = insn_q;
   assign out_rd           = insn_q[11:7];
   assign out_rs1          = insn_q[19:15];
   assign out_rs2          = insn_q[24:20];
   assign out_reg_write    = ctrl_q.reg_write;
   assign out_imm_data     = ctrl_q.imm_data;
   assign out_mem_to_reg   = ctrl_q.mem_to_reg;
   assign out_branch       = ctrl_q.branch;
   assign out_wb_pc        = ctrl_q.wb_pc;
   assign out_cond_b       = ctrl_q.cond_b;
   assign out_store        = ctrl_q.store;
   assign out_jalr         = ctrl_q.jalr;
   assign out_auipc        = ctrl_q.auipc;
   assign out_lui          = ctrl_q.lui;
   assign out_is_fstore    = ctrl_q.is_fstore;
   assign out_fp_reg_write = ctrl_q.fp_reg_write;
   assign out_illegal      = ctrl_q.illegal;
   assign out_alu_op       = ctrl_q.alu_op;
   assign stall_cnt        = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: directed scenarios plus random traffic against a cycle-level reference model.
module tb_decode_ctrl_stage;
   localparam int CW = 3;

   localparam logic [6:0] O_LOAD = 7'b0000011, O_FLOAD = 7'b0000111, O_OPIMM = 7'b0010011,
                          O_AUIPC = 7'b0010111, O_STORE = 7'b0100011, O_FSTORE = 7'b0100111,
                          O_OP = 7'b0110011, O_LUI = 7'b0110111, O_OPFP = 7'b1010011,
                          O_BR = 7'b1100011, O_JALR = 7'b1100111, O_JAL = 7'b1101111;

   // bundle bit positions
   localparam int B_RW = 14, B_IMM = 13, B_M2R = 12, B_BR = 11, B_WBPC = 10, B_CB = 9,
                  B_ST = 8, B_JALR = 7, B_AUIPC = 6, B_LUI = 5, B_FS = 4, B_FPRW = 3, B_ILL = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
   logic [31:0]   a_in_insn, a_in_pc, a_out_pc, a_out_insn;
   logic [4:0]    a_rd, a_rs1, a_rs2;
   logic          a_rw, a_imm, a_m2r, a_br, a_wbpc, a_cb, a_st, a_jalr, a_auipc, a_lui, a_fs, a_fprw, a_ill;
   logic [1:0]    a_alu;
   logic [CW-1:0] a_cnt;
   logic [14:0]   a_bundle;
   assign a_bundle = {a_rw, a_imm, a_m2r, a_br, a_wbpc, a_cb, a_st, a_jalr, a_auipc, a_lui,
                      a_fs, a_fprw, a_ill, a_alu};

   logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [31:0]   b_in_insn, b_in_pc, b_out_pc, b_out_insn;
   logic [4:0]    b_rd, b_rs1, b_rs2;
   logic          b_rw, b_imm, b_m2r, b_br, b_wbpc, b_cb, b_st, b_jalr, b_auipc, b_lui, b_fs, b_fprw, b_ill;
   logic [1:0]    b_alu;
   logic [15:0]   b_cnt;

   decode_ctrl_stage #(.PC_W(32), .LOAD_USE_STALL(1'b1), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_insn(a_in_insn), .in_pc(a_in_pc), .flush(a_flush), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_pc(a_out_pc), .out_insn(a_out_insn), .out_rd(a_rd),
      .out_rs1(a_rs1), .out_rs2(a_rs2), .out_reg_write(a_rw), .out_imm_data(a_imm),
      .out_mem_to_reg(a_m2r), .out_branch(a_br), .out_wb_pc(a_wbpc), .out_cond_b(a_cb),
      .out_store(a_st), .out_jalr(a_jalr), .out_auipc(a_auipc), .out_lui(a_lui),
      .out_is_fstore(a_fs), .out_fp_reg_write(a_fprw), .out_illegal(a_ill),
      .out_alu_op(a_alu), .stall_cnt(a_cnt)
   );

   decode_ctrl_stage #(.PC_W(32), .LOAD_USE_STALL(1'b0), .CNT_W(16)) dut_nostall (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_insn(b_in_insn), .in_pc(b_in_pc), .flush(b_flush), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_pc(b_out_pc), .out_insn(b_out_insn), .out_rd(b_rd),
      .out_rs1(b_rs1), .out_rs2(b_rs2), .out_reg_write(b_rw), .out_imm_data(b_imm),
      .out_mem_to_reg(b_m2r), .out_branch(b_br), .out_wb_pc(b_wbpc), .out_cond_b(b_cb),
      .out_store(b_st), .out_jalr(b_jalr), .out_auipc(b_auipc), .out_lui(b_lui),
      .out_is_fstore(b_fs), .out_fp_reg_write(b_fprw), .out_illegal(b_ill),
      .out_alu_op(b_alu), .stall_cnt(b_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] exp_bundle(input logic [6:0] o);
      logic [14:0] b;
      b = '0;
      b[1:0] = 2'b10;
      case (o)
         O_OPIMM: begin b[B_RW] = 1; b[B_IMM] = 1; b[1:0] = 2'b01; end
         O_OP:    begin b[B_RW] = 1; b[1:0] = 2'b11; end
         O_JAL:   begin b[B_RW] = 1; b[B_BR] = 1; b[B_WBPC] = 1; end
         O_JALR:  begin b[B_RW] = 1; b[B_IMM] = 1; b[B_BR] = 1; b[B_WBPC] = 1; b[B_JALR] = 1; end
         O_LOAD:  begin b[B_RW] = 1; b[B_IMM] = 1; b[B_M2R] = 1; end
         O_LUI:   begin b[B_RW] = 1; b[B_IMM] = 1; b[B_LUI] = 1; end
         O_AUIPC: begin b[B_RW] = 1; b[B_IMM] = 1; b[B_AUIPC] = 1; end
         O_STORE: begin b[B_IMM] = 1; b[B_ST] = 1; end
         O_BR:    begin b[B_BR] = 1; b[B_CB] = 1; b[1:0] = 2'b00; end
`ifdef DECODE_CTRL_STAGE_FPU_EN
         O_FLOAD:  begin b[B_IMM] = 1; b[B_FPRW] = 1; end
         O_FSTORE: begin b[B_IMM] = 1; b[B_ST] = 1; b[B_FS] = 1; end
         O_OPFP:   begin b[B_FPRW] = 1; end
`endif
         default: b[B_ILL] = 1;
      endcase
      return b;
   endfunction

   function automatic bit hz_of(input logic [31:0] held, input logic [31:0] nw);
      logic [6:0] ho, no;
      logic [4:0] rd, r1, r2;
      bit reads1, reads2;
      ho = held[6:0]; no = nw[6:0];
      rd = held[11:7]; r1 = nw[19:15]; r2 = nw[24:20];
      reads1 = no inside {O_OP, O_OPIMM, O_LOAD, O_STORE, O_BR, O_JALR};
      reads2 = no inside {O_OP, O_STORE, O_BR};
`ifdef DECODE_CTRL_STAGE_FPU_EN
      reads1 = reads1 || (no inside {O_FLOAD, O_FSTORE});
      if (ho == O_FLOAD && ((no == O_OPFP && (r1 == rd || r2 == rd)) || (no == O_FSTORE && r2 == rd)))
         return 1'b1;
`endif
      return ho == O_LOAD && rd != 5'd0 && ((reads1 && r1 == rd) || (reads2 && r2 == rd));
   endfunction

   // Reference state for the stalling instance
   bit          m_valid;
   logic [14:0] m_bundle;
   logic [31:0] m_insn, m_pc;
   int          m_cnt;

   task automatic model_reset();
      m_valid = 0; m_bundle = '0; m_insn = '0; m_pc = '0; m_cnt = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"},  a_out_valid, m_valid);
      check({tag, ".bundle"}, a_bundle, m_bundle);
      check({tag, ".pc"},     a_out_pc, m_pc);
      check({tag, ".insn"},   a_out_insn, m_insn);
      check({tag, ".regs"},   {a_rd, a_rs1, a_rs2}, {m_insn[11:7], m_insn[19:15], m_insn[24:20]});
      check({tag, ".cnt"},    a_cnt, m_cnt);
   endtask

   // Called just after a falling edge: drive, check ready, advance one cycle, check outputs.
   task automatic step(input logic iv, input logic [31:0] insn, input logic [31:0] pc,
                       input logic ordy, input logic fl);
      bit hz, rdy;
      a_in_valid = iv; a_in_insn = insn; a_in_pc = pc; a_out_ready = ordy; a_flush = fl;
      #1;
      hz  = m_valid && hz_of(m_insn, insn);
      rdy = !fl && (!m_valid || ordy) && !hz;
      check("in_ready", a_in_ready, rdy);
      @(posedge clk);
      if (iv && hz && !fl && m_cnt < (1 << CW) - 1) m_cnt++;
      if (fl) m_valid = 0;
      else if (iv && rdy) begin
         m_valid = 1; m_insn = insn; m_pc = pc; m_bundle = exp_bundle(insn[6:0]);
      end else if (ordy) m_valid = 0;
      @(negedge clk);
      check_outputs("cyc");
   endtask

   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst");
      #1 rst_n = 1'b1;
   endtask

   logic [6:0] opc_tab[14] = '{O_LOAD, O_FLOAD, O_OPIMM, O_AUIPC, O_STORE, O_FSTORE, O_OP,
                               O_LUI, O_OPFP, O_BR, O_JALR, O_JAL, 7'b1111111, 7'b0001011};

   function automatic logic [31:0] rand_insn();
      logic [31:0] r;
      r = $urandom;
      r[6:0]   = opc_tab[$urandom_range(0, 13)];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      return r;
   endfunction

   localparam logic [31:0] ADDI = 32'h00500093, LW = 32'h0000A103, ADD = 32'h002101B3,
                           LW0 = 32'h0000A003, ADD0 = 32'h000001B3, JAL = 32'h000000EF,
                           BEQ = 32'h00000063, FSW = 32'h0020A027;

   initial begin
      rst_n = 1'b0;
      {a_in_valid, a_flush, a_out_ready} = '0; a_in_insn = '0; a_in_pc = '0;
      {b_in_valid, b_flush, b_out_ready} = '0; b_in_insn = '0; b_in_pc = '0;
      model_reset();
      @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;

      step(1, ADDI, 32'h100, 1, 0);
      check("addi.rd", a_rd, 5'd1);
      check("addi.alu", a_alu, 2'b01);
      check("addi.rw_imm", {a_rw, a_imm}, 2'b11);

      step(1, LW, 32'h104, 1, 0);
      step(1, ADD, 32'h108, 1, 0);
      check("bubble.valid", a_out_valid, 1'b0);
      step(1, ADD, 32'h108, 1, 0);
      check("luse.cnt", a_cnt, 1);
      step(1, LW0, 32'h10c, 1, 0);
      step(1, ADD0, 32'h110, 1, 0);
      check("x0.nostall", a_cnt, 1);

      step(1, JAL, 32'h114, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, ADDI, 32'h118, 0, 0);
         check("jal.hold", {a_br, a_wbpc, a_in_ready}, 3'b110);
      end
      step(0, ADDI, 32'h118, 1, 0);
      check("jal.drain", a_out_valid, 1'b0);

      step(1, BEQ, 32'h200, 0, 0);
      step(1, ADDI, 32'h204, 0, 1);
      check("flush.valid", a_out_valid, 1'b0);
      step(0, ADDI, 32'h204, 1, 0);

      step(1, FSW, 32'h300, 1, 0);
`ifdef DECODE_CTRL_STAGE_FPU_EN
      check("fsw.ctrl", {a_st, a_fs, a_ill}, 3'b110);
`else
      check("fsw.ctrl", a_bundle, 15'b000000000000110);
`endif

      step(1, LW, 32'h400, 0, 0);
      step(1, ADD, 32'h404, 0, 0);
      pulse_reset();
      check("midrst.zero", {a_out_valid, a_cnt, a_bundle}, '0);
      step(0, 32'h0, 32'h0, 1, 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 249) == 0) pulse_reset();
         step(1'($urandom_range(0, 3) != 0), rand_insn(), $urandom,
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
      end

      b_in_valid = 1; b_in_insn = LW; b_out_ready = 1;
      @(posedge clk); @(negedge clk);
      check("nostall.lw", {b_out_valid, b_out_insn}, {1'b1, LW});
      b_in_insn = ADD;
      #1 check("nostall.ready", b_in_ready, 1'b1);
      @(posedge clk); @(negedge clk);
      check("nostall.add", {b_out_valid, b_out_insn}, {1'b1, ADD});
      check("nostall.cnt", b_cnt, 16'd0);
      b_in_valid = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, handshaked instruction-decode stage for the RV32I core. It accepts one 32-bit instruction per cycle and decodes the opcode into the core's control bundle (reg_write, imm_data, ALU class, branch/writeback, load/store, jalr/auipc/lui). Results are held in a single pipeline register that feeds execute. It also detects load-use hazards against the instruction it holds, flushes on redirect, counts stall cycles, and optionally decodes F-extension opcodes.

## Interface
- PC_W, 32, width of the carried program counter
- LOAD_USE_STALL, 1, 1 = insert a load-use bubble; 0 = no hazard check, `in_ready` ignores rs/rd matches
- CNT_W, 16, width of the saturating stall counter
- clk  in  1  clock. One clock domain only.
- rst_n  in  1  reset. Asynchronous, active-low.
- in_valid  in  1  instruction available
- in_ready  out  1  stage accepts the instruction this cycle
- in_insn  in  32  raw instruction
- in_pc  in  PC_W  PC of `in_insn`
- flush  in  1  synchronous kill of the held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes the bundle
- out_pc, out_insn  out  PC_W, 32  registered copies
- out_rd, out_rs1, out_rs2  out  5 each  `insn[11:7]`, `insn[19:15]`, `insn[24:20]`
- out_reg_write, out_imm_data, out_mem_to_reg, out_branch, out_wb_pc, out_cond_b, out_store, out_jalr, out_auipc, out_lui, out_is_fstore, out_fp_reg_write, out_illegal  out  1 each  control bundle
- out_alu_op  out  2  00 branch compare, 01 op-imm, 10 add, 11 reg-reg
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- **Decode.** Decoding is done on `in_insn[6:0]` combinationally and registered on accept, where accept = `in_valid & in_ready`.
- **reg_write = 1:** op-imm (0010011), op (0110011), jal (1101111), jalr (1100111), load (0000011), lui (0110111), auipc (0010111).
- **imm_data = 1:** op-imm, load, store (0100011), jalr, lui, auipc. Also fload and fstore when FPU is enabled.
- **alu_op:** 01 for op-imm, 11 for op, 00 for branch (1100011), 10 for everything else.
- **branch/wb_pc:** jal and jalr give 1/1; branch gives 1/0; all others give 0/0.
- **Single-opcode flags:** cond_b = branch; mem_to_reg = load; jalr, lui and auipc are set by their own opcode.
- **store:** set for 0100011, and for 0100111 when FPU is enabled.
- **Illegal opcode.** Any opcode not listed and not enabled sets out_illegal=1. All other control bits are 0 and alu_op=10. The instruction still flows through the stage.
- **Ready rule.** in_ready = !flush & (!out_valid | out_ready) & !hazard.
- **Hazard.** hazard is asserted when all of the following hold:
  - LOAD_USE_STALL=1;
  - out_valid=1 and out_mem_to_reg=1 and out_rd≠0;
  - the input reads that rd, i.e. in rs1==out_rd and the opcode uses rs1, or in rs2==out_rd and the opcode uses rs2.
- **rs1 users:** op, op-imm, load, store, branch, jalr, fload, fstore.
- **rs2 users:** op, store, branch.
- **Bubble.** While hazard=1 the held load may still drain. On the cycle after the load drains, out_valid=0, so the dependent instruction is accepted then. The result is exactly one empty cycle at the output.
- **Output register.**
  - On accept: load the bundle and set out_valid=1.
  - Else on out_ready: clear out_valid.
  - Else: hold all outputs stable.
- **Flush** has priority over everything else. out_valid goes to 0 next cycle, in_ready=0 during the flush cycle, and the incoming instruction is dropped.
- **stall_cnt** increments on each cycle with `in_valid & hazard & !flush`, saturating at all-ones. It is reset only by rst_n.

## Timing
- Latency: accept at edge N gives out_valid=1 from N+1. Throughput is 1 per cycle with no hazard.
- Back-pressure: when out_valid & !out_ready, in_ready=0 and the outputs are frozen. in_ready depends combinationally on out_ready and flush.
- Simultaneous drain and accept (out_ready=1, in_valid=1) replaces the bundle in the same edge with no bubble.
- Reset, asserted asynchronously at any time including mid-stall:
  - out_valid=0, stall_cnt=0;
  - every out_* control bit 0, out_alu_op=00;
  - out_pc, out_insn and register fields 0;
  - in_ready=1 from the first cycle after release.

## Configuration
- Macro: DECODE_CTRL_STAGE_FPU_EN.
- **Defined:**
  - 0000111 (fload): imm_data=1, fp_reg_write=1.
  - 0100111 (fstore): imm_data=1, store=1, is_fstore=1.
  - 1010011 (op-fp): fp_reg_write=1, alu_op=10.
  - The hazard check is extended: a held fload (fp_reg_write with fload opcode) stalls an op-fp reading rs1/rs2 == out_rd, and an fstore reading rs2 == out_rd. f0 is not exempt.
- **Undefined:** these three opcodes are illegal, out_fp_reg_write and out_is_fstore are tied to 0, and the fp hazard logic is absent.

## Test plan
- Reset then `addi x1,x0,5` (0x00500093) with out_ready=1 → next cycle out_valid=1, reg_write=1, imm_data=1, alu_op=01, out_rd=1.
- `lw x2,0(x1)` then `add x3,x2,x2` back-to-back with out_ready=1 → load at N+1; one cycle with out_valid=0; add at N+3; stall_cnt=1.
- Same pair with LOAD_USE_STALL=0, or using rd=x0 → no bubble, stall_cnt=0.
- `jal` with out_ready=0 for 3 cycles → branch=1 and wb_pc=1 held stable, in_ready=0 throughout; the bundle drains on the 4th cycle.
- flush while holding `beq` with in_valid=1 → next cycle out_valid=0 and the incoming instruction never appears; rst_n pulsed mid-stall → all outputs zero and stall_cnt=0.
- `fsw` (opcode 0100111) → with the macro: store=1, is_fstore=1, illegal=0; without it: illegal=1 and all other control bits 0.
